yolo_layer_sequencer: RTL and testbench

Programmable layer scheduler for the YOLO inference datapath. It replaces fixed enable levels with per-stage start/done handshakes. A small per-layer config table selects which stages run for each layer: fetch, conv, pool, activation, FC. After the last layer it runs detection, then signals completion; a per-stage watchdog flags hung units.

---
 rtl/yolo_ctrl_pkg.sv | 48 ++++
 rtl/yolo_stage_watchdog.sv | 34 +++
 rtl/yolo_layer_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_yolo_layer_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/yolo_ctrl_pkg.sv
// Shared types for the YOLO layer sequencer: FSM states, stage codes,
// layer-config bit positions and the default watchdog limit.
package yolo_ctrl_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_CYC = 4096;

  localparam int CFG_POOL = 0;
  localparam int CFG_ACT  = 1;
  localparam int CFG_FC   = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CONV,
    ST_POOL,
    ST_ACT,
    ST_FC,
    ST_DETECT,
    ST_FINISH,
    ST_ERR
  } state_e;

  typedef enum logic [2:0] {
    STG_FETCH  = 3'd0,
    STG_CONV   = 3'd1,
    STG_POOL   = 3'd2,
    STG_ACT    = 3'd3,
    STG_FC     = 3'd4,
    STG_DETECT = 3'd5
  } stage_e;

  function automatic stage_e stage_of(input state_e s);
    case (s)
      ST_CONV:   return STG_CONV;
      ST_POOL:   return STG_POOL;
      ST_ACT:    return STG_ACT;
      ST_FC:     return STG_FC;
      ST_DETECT: return STG_DETECT;
      default:   return STG_FETCH;
    endcase
  endfunction

  // True for the states that wait on a unit's done handshake.
  function automatic logic is_stage(input state_e s);
    return s inside {ST_FETCH, ST_CONV, ST_POOL, ST_ACT, ST_FC, ST_DETECT};
  endfunction

endpackage

// File: rtl/yolo_stage_watchdog.sv
// Per-stage hang detector: counts cycles spent waiting for a done and
// flags a timeout once the count reaches TIMEOUT_CYC-1.
module yolo_stage_watchdog
  import yolo_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter int unsigned TMO_W       = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !timeout) begin
      cnt_q <= cnt_q + TMO_W'(1);
    end
  end

  assign timeout = en && (cnt_q == LIMIT);

endmodule

// File: rtl/yolo_layer_sequencer.sv
// Layer scheduler: walks a per-layer stage list with start/done handshakes,
// runs detection after the last layer and traps hung stages in ERR.
module yolo_layer_sequencer
  import yolo_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LAYERS  = 8,
  parameter int unsigned LAYER_W     = 3,
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter int unsigned TMO_W       = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LAYER_W:0]   num_layers,
  input  logic               cfg_we,
  input  logic [LAYER_W-1:0] cfg_addr,
  input  logic [2:0]         cfg_data,
  input  logic               err_clear,
  output logic               fetch_start,
  output logic               conv_start,
  output logic               pool_start,
  output logic               act_start,
  output logic               fc_start,
  output logic               detect_start,
  input  logic               fetch_done,
  input  logic               conv_done,
  input  logic               pool_done,
  input  logic               act_done,
  input  logic               fc_done,
  input  logic               detect_done,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               frame_done,
  output logic               error,
  output logic [2:0]         err_stage
);

  localparam logic [LAYER_W:0] MAX_N = (LAYER_W + 1)'(MAX_LAYERS);

  state_e             state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [LAYER_W:0]   count_q, count_d;
  logic [2:0]         err_stage_q, err_stage_d;
  logic               frame_done_q, frame_done_d;
  logic [5:0]         pulse_q, pulse_d;
  logic [2:0]         cfg_q [MAX_LAYERS];

  logic               enter, advance, waiting, tmo, cur_done;
  logic [7:0]         done_v;
  logic [2:0]         cur_cfg;
  logic [LAYER_W:0]   clamp_n, next_idx;
  stage_e             cur_stage;

  assign done_v    = {2'b00, detect_done, fc_done, act_done, pool_done, conv_done, fetch_done};
  assign cur_stage = stage_of(state_q);
  assign waiting   = is_stage(state_q);
  // The cycle carrying the start pulse never accepts a done.
  assign cur_done  = waiting && !(|pulse_q) && done_v[cur_stage];
  assign cur_cfg   = cfg_q[layer_q];
  assign clamp_n   = (num_layers > MAX_N) ? MAX_N : num_layers;
  assign next_idx  = {1'b0, layer_q} + (LAYER_W + 1)'(1);

  // NOTE: the config table is reset explicitly because a cleared table
  // (conv-only layers) is the defined power-on configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(MAX_LAYERS); i++) cfg_q[i] <= '0;
    end else if (cfg_we && (state_q == ST_IDLE || state_q == ST_ERR)) begin
      cfg_q[cfg_addr] <= cfg_data;
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case can infer a latch.
  always_comb begin
    state_d      = state_q;
    layer_d      = layer_q;
    count_d      = count_q;
    err_stage_d  = err_stage_q;
    frame_done_d = 1'b0;
    enter        = 1'b0;
    advance      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d = clamp_n;
          layer_d = '0;
          enter   = 1'b1;
          state_d = (clamp_n == '0) ? ST_DETECT : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (cur_done) begin
          enter   = 1'b1;
          state_d = cur_cfg[CFG_FC] ? ST_FC : ST_CONV;
        end
      end
      ST_CONV: begin
        if (cur_done) begin
          if (cur_cfg[CFG_POOL]) begin
            enter   = 1'b1;
            state_d = ST_POOL;
          end else if (cur_cfg[CFG_ACT]) begin
            enter   = 1'b1;
            state_d = ST_ACT;
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_POOL, ST_FC: begin
        if (cur_done) begin
          if (cur_cfg[CFG_ACT]) begin
            enter   = 1'b1;
            state_d = ST_ACT;
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_ACT: begin
        if (cur_done) advance = 1'b1;
      end
      ST_DETECT: begin
        if (cur_done) begin
          state_d      = ST_FINISH;
          frame_done_d = 1'b1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_ERR: begin
        if (err_clear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      enter = 1'b1;
      if (next_idx == count_q) begin
        state_d = ST_DETECT;
      end else begin
        state_d = ST_FETCH;
        layer_d = next_idx[LAYER_W-1:0];
      end
    end

    // A done landing in the timeout cycle keeps the stage alive.
    if (waiting && tmo && !cur_done) begin
      state_d     = ST_ERR;
      err_stage_d = cur_stage;
      enter       = 1'b0;
    end
  end

  assign pulse_d = enter ? (6'b000001 << stage_of(state_d)) : 6'b000000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      layer_q      <= '0;
      count_q      <= '0;
      err_stage_q  <= '0;
      frame_done_q <= 1'b0;
      pulse_q      <= '0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      count_q      <= count_d;
      err_stage_q  <= err_stage_d;
      frame_done_q <= frame_done_d;
      pulse_q      <= pulse_d;
    end
  end

  yolo_stage_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TMO_W      (TMO_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (enter || !waiting),
    .en     (waiting),
    .timeout(tmo)
  );

  assign fetch_start  = pulse_q[STG_FETCH];
  assign conv_start   = pulse_q[STG_CONV];
  assign pool_start   = pulse_q[STG_POOL];
  assign act_start    = pulse_q[STG_ACT];
  assign fc_start     = pulse_q[STG_FC];
  assign detect_start = pulse_q[STG_DETECT];
  assign layer_idx    = layer_q;
  assign busy         = !(state_q inside {ST_IDLE, ST_ERR});
  assign frame_done   = frame_done_q;
  assign error        = (state_q == ST_ERR);
  assign err_stage    = err_stage_q;

endmodule

// File: tb/tb_yolo_layer_sequencer.sv
// Self-checking bench: emulated stage units with random latencies and stray
// inputs, compared against a stage-list model built from the config table.
module tb_yolo_layer_sequencer;

  localparam int TMO = 16;
  localparam int C_FETCH = 0, C_CONV = 1, C_POOL = 2, C_ACT = 3, C_FC = 4, C_DETECT = 5;

  logic       clk = 1'b0;
  logic       rst, start, cfg_we, err_clear;
  logic [3:0] num_layers;
  logic [2:0] cfg_addr, cfg_data;
  logic [5:0] done_v;
  wire  [5:0] st_v;
  wire  [2:0] layer_idx, err_stage;
  wire        busy, frame_done, error;
  wire        fetch_start, conv_start, pool_start, act_start, fc_start, detect_start;

  always #5 clk = ~clk;

  assign st_v = {detect_start, fc_start, act_start, pool_start, conv_start, fetch_start};

  yolo_layer_sequencer #(
    .MAX_LAYERS(8), .LAYER_W(3), .TIMEOUT_CYC(TMO), .TMO_W(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_layers(num_layers),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .err_clear(err_clear),
    .fetch_start(fetch_start), .conv_start(conv_start), .pool_start(pool_start),
    .act_start(act_start), .fc_start(fc_start), .detect_start(detect_start),
    .fetch_done(done_v[0]), .conv_done(done_v[1]), .pool_done(done_v[2]),
    .act_done(done_v[3]), .fc_done(done_v[4]), .detect_done(done_v[5]),
    .layer_idx(layer_idx), .busy(busy), .frame_done(frame_done),
    .error(error), .err_stage(err_stage)
  );

  int n_cmp = 0, n_err = 0, cyc = 0;
  int obs_code[$], obs_layer[$], exp_code[$], exp_layer[$];
  int mcfg[8];
  int fd_count, err_seen, err_cyc, slow_start_cyc, detect_done_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic write_cfg(input int a, input int d);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_data = 3'(d);
    tick();
    cfg_we = 1'b0;
    mcfg[a] = d;
  endtask

  // Stage list a frame must produce, straight from the layer rules.
  task automatic build_exp(input int n);
    int m;
    m = (n > 8) ? 8 : n;
    exp_code.delete(); exp_layer.delete();
    for (int l = 0; l < m; l++) begin
      exp_code.push_back(C_FETCH); exp_layer.push_back(l);
      if ((mcfg[l] & 4) != 0) begin
        exp_code.push_back(C_FC); exp_layer.push_back(l);
      end else begin
        exp_code.push_back(C_CONV); exp_layer.push_back(l);
        if ((mcfg[l] & 1) != 0) begin
          exp_code.push_back(C_POOL); exp_layer.push_back(l);
        end
      end
      if ((mcfg[l] & 2) != 0) begin
        exp_code.push_back(C_ACT); exp_layer.push_back(l);
      end
    end
    exp_code.push_back(C_DETECT); exp_layer.push_back(-1);
  endtask

  task automatic compare_seq(input string tag, input int n);
    int len;
    build_exp(n);
    check({tag, "_len"}, obs_code.size(), exp_code.size());
    len = (obs_code.size() < exp_code.size()) ? obs_code.size() : exp_code.size();
    for (int i = 0; i < len; i++) begin
      check($sformatf("%s_code%0d", tag, i), obs_code[i], exp_code[i]);
      if (exp_layer[i] >= 0) check($sformatf("%s_layer%0d", tag, i), obs_layer[i], exp_layer[i]);
    end
  endtask

  // Emulates the stage units. slow_delay 0 withholds the slow stage's done.
  task automatic run_frame(input int n, input int fix_delay, input int slow_code,
                           input int slow_delay, input bit noise, input bit expect_err,
                           input int abort_code, input int abort_layer);
    int pend_code, pend_left, last_done_cyc, code;
    bit pend_hold, done_flag;
    obs_code.delete(); obs_layer.delete();
    fd_count = 0; err_seen = 0; err_cyc = -1; slow_start_cyc = -1; detect_done_cyc = -100;
    pend_code = -1; pend_left = 0; pend_hold = 1'b0; done_flag = 1'b0;
    start = 1'b1; num_layers = 4'(n);
    last_done_cyc = cyc;
    tick();
    for (int i = 0; i < 2000 && !done_flag; i++) begin
      start = 1'b0; cfg_we = 1'b0; done_v = '0;
      if (|st_v) begin
        code = 0;
        for (int k = 0; k < 6; k++) if (st_v[k]) code = k;
        check("one_start", $countones(st_v), 1);
        check("start_latency", cyc, last_done_cyc + 1);
        obs_code.push_back(code); obs_layer.push_back(int'(layer_idx));
        if (code == abort_code && int'(layer_idx) == abort_layer) return;
        pend_code = code; pend_hold = 1'b0;
        if (code == slow_code) begin
          slow_start_cyc = cyc;
          pend_left = slow_delay;
          pend_hold = (slow_delay == 0);
        end else begin
          pend_left = (fix_delay > 0) ? fix_delay : $urandom_range(1, 4);
        end
        if (noise && $urandom_range(0, 1) == 1) done_v[code] = 1'b1;
      end else if (pend_code >= 0 && !pend_hold) begin
        pend_left--;
        if (pend_left == 0) begin
          done_v[pend_code] = 1'b1;
          last_done_cyc = cyc;
          if (pend_code == C_DETECT) detect_done_cyc = cyc;
          pend_code = -1;
        end
      end
      if (frame_done === 1'b1) begin
        fd_count++;
        check("frame_done_latency", cyc, detect_done_cyc + 1);
        done_flag = 1'b1;
      end else if (error === 1'b1) begin
        err_seen = 1; err_cyc = cyc; done_flag = 1'b1;
      end else begin
        if (noise && busy === 1'b1 && pend_code >= 0) begin
          for (int c = 0; c < 6; c++)
            if (c != pend_code && $urandom_range(0, 3) == 0) done_v[c] = 1'b1;
          start = ($urandom_range(0, 3) == 0);
          num_layers = 4'($urandom_range(0, 15));
          cfg_we = ($urandom_range(0, 3) == 0);
          cfg_addr = 3'($urandom_range(0, 7));
          cfg_data = 3'($urandom_range(0, 7));
        end
        tick();
      end
    end
    start = 1'b0; cfg_we = 1'b0; done_v = '0;
    if (expect_err) begin
      check("err_seen", err_seen, 1);
    end else begin
      check("frame_end_once", fd_count, 1);
      check("no_error", err_seen, 0);
      tick();
      check("idle_after_frame", {busy, frame_done}, 2'b00);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, {st_v, busy, frame_done, error}, 9'd0);
    check({tag, "_layer"}, layer_idx, 0);
    check({tag, "_err_stage"}, err_stage, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_layers = '0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_data = '0; err_clear = 1'b0; done_v = '0;
    for (int i = 0; i < 8; i++) mcfg[i] = 0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Default conv-only table, fixed 3-cycle unit latency.
    run_frame(2, 3, -1, 0, 1'b0, 1'b0, -1, -1);
    compare_seq("default2", 2);

    // Pool+act layer followed by an fc+act layer.
    write_cfg(0, 3'b011);
    write_cfg(1, 3'b110);
    run_frame(2, 2, -1, 0, 1'b0, 1'b0, -1, -1);
    compare_seq("mixed2", 2);
    check("mixed2_no_conv_l1", obs_code.size() > 5 ? obs_code[5] : -1, C_FC);

    // Zero layers goes straight to detection.
    run_frame(0, 0, -1, 0, 1'b0, 1'b0, -1, -1);
    compare_seq("zero", 0);

    // Stray dones, starts and config writes while busy.
    run_frame(3, 0, -1, 0, 1'b1, 1'b0, -1, -1);
    compare_seq("noisy", 3);

    // Random tables and lengths, including clamped counts.
    for (int f = 0; f < 6; f++) begin
      for (int a = 0; a < 8; a++) write_cfg(a, $urandom_range(0, 7));
      begin
        int n;
        bit nz;
        n = $urandom_range(0, 15);
        nz = 1'($urandom_range(0, 1));
        run_frame(n, 0, -1, 0, nz, 1'b0, -1, -1);
        compare_seq($sformatf("rand%0d", f), n);
      end
    end

    // Done in the very last allowed cycle still counts.
    write_cfg(0, 3'b000);
    run_frame(1, 0, C_CONV, TMO - 1, 1'b0, 1'b0, -1, -1);
    compare_seq("tmo_edge", 1);

    // Withheld conv_done trips the watchdog.
    run_frame(1, 0, C_CONV, 0, 1'b0, 1'b1, -1, -1);
    check("tmo_cycles", err_cyc - slow_start_cyc, TMO);
    check("tmo_err_stage", err_stage, C_CONV);
    check("tmo_busy", busy, 1'b0);
    start = 1'b1; num_layers = 4'd1;
    tick();
    start = 1'b0;
    check("err_ignores_start", {error, busy, st_v}, {1'b1, 1'b0, 6'd0});
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("err_clear_state", {error, busy}, 2'b00);
    check("err_stage_held", err_stage, C_CONV);

    // Reset during layer-1 pool, then a frame on the cleared table.
    write_cfg(0, 3'b001);
    write_cfg(1, 3'b001);
    run_frame(2, 0, -1, 0, 1'b0, 1'b0, C_POOL, 1);
    check("reached_pool_l1", obs_code.size(), 6);
    #2 rst = 1'b1;
    #1 check_all_zero("midreset");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mcfg[i] = 0;
    tick();
    run_frame(2, 0, -1, 0, 1'b0, 1'b0, -1, -1);
    compare_seq("post_reset", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
